// File: rtl/rx_frame_ctrl.sv
// UART receive framing controller: tracks start/data/parity/stop bits against the
// oversampling counter and publishes the received word when the frame is clean.
//
// state  | meaning
// IDLE   | line idle, waiting for RX_IN low
// START  | checking the start bit; a high sample at bit end is a glitch
// DATA   | shifting DATA_WIDTH data bits, LSB first
// PARITY | comparing the parity bit against the captured parity mode
// STOP   | checking the stop bit; a clean frame publishes P_DATA
module rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  data_samp_en,
  output logic [5:0]            edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                state;
  logic [3:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  bit_end;
  logic                  par_exp;

  assign bit_end = (state != IDLE) && (edge_cnt == (Prescale - 6'd1));
  // Odd parity expects the inverse of the data XOR.
  assign par_exp = (^shift_reg) ^ par_typ_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
      data_samp_en <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (state != IDLE)
        edge_cnt <= bit_end ? '0 : edge_cnt + 6'd1;

      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state        <= START;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            data_samp_en <= 1'b1;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
            par_en_q     <= PAR_EN;
            par_typ_q    <= PAR_TYP;
          end
        end
        START: begin
          if (bit_end) begin
            if (sampled_bit) begin
              state        <= IDLE;
              data_samp_en <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            par_err <= (sampled_bit != par_exp);
            state   <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            stp_err      <= ~sampled_bit;
            state        <= IDLE;
            data_samp_en <= 1'b0;
            if (sampled_bit && !par_err) begin
              data_valid <= 1'b1;
              P_DATA     <= shift_reg;
            end
          end
        end
        default: begin
          state        <= IDLE;
          data_samp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
